// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: two-flop synchroniser, per-phase stability filter,
// x4 Gray-code step decode and a loadable, wrapping position counter.
module quad_decoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FILT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_a,
  input  logic             ch_b,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] init,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int unsigned PW = $clog2(FILT + 2);

  logic [1:0]          s1_q, s2_q;
  logic [1:0]          filt_q, filt_d;
  logic [1:0]          prev_q, prev_d;
  logic [1:0][CW-1:0]  fcnt_q, fcnt_d;
  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic                primed_q, primed_d;

  logic [WIDTH-1:0]    count_d;
  logic                dir_d, step_d, err_d;
  logic [1:0]          chg;
  logic                illegal, single, up;

  // Filter and priming; the first accepted level after reset is taken blindly.
  always_comb begin
    filt_d   = filt_q;
    prev_d   = filt_q;
    fcnt_d   = fcnt_q;
    pcnt_d   = pcnt_q;
    primed_d = primed_q;
    if (!primed_q) begin
      if (pcnt_q == PW'(FILT + 1)) begin
        filt_d   = s2_q;
        prev_d   = s2_q;
        primed_d = 1'b1;
        fcnt_d   = '0;
      end else begin
        pcnt_d = pcnt_q + PW'(1);
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          fcnt_d[i] = '0;
        end else if (fcnt_q[i] == CW'(FILT - 1)) begin
          filt_d[i] = s2_q[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Decode the filt update seen on the previous edge, then update counter state.
  always_comb begin
    chg     = filt_q ^ prev_q;
    illegal = (chg == 2'b11);
    single  = (chg == 2'b01) || (chg == 2'b10);
    case ({prev_q, filt_q})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: up = 1'b1;
      default:                                up = 1'b0;
    endcase

    count_d = count;
    dir_d   = dir;
    step_d  = 1'b0;
    err_d   = err;

    if (illegal) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    if (load) begin
      count_d = init;
    end else if (single && en) begin
      step_d  = 1'b1;
      dir_d   = up;
      count_d = up ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= 2'b00;
      s2_q     <= 2'b00;
      filt_q   <= 2'b00;
      prev_q   <= 2'b00;
      fcnt_q   <= '0;
      pcnt_q   <= '0;
      primed_q <= 1'b0;
      count    <= '0;
      dir      <= 1'b0;
      step     <= 1'b0;
      err      <= 1'b0;
    end else begin
      s1_q     <= {ch_a, ch_b};
      s2_q     <= s1_q;
      filt_q   <= filt_d;
      prev_q   <= prev_d;
      fcnt_q   <= fcnt_d;
      pcnt_q   <= pcnt_d;
      primed_q <= primed_d;
      count    <= count_d;
      dir      <= dir_d;
      step     <= step_d;
      err      <= err_d;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios then random phase steps, checked
// against a Gray-position model of the encoder.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ch_a = 1'b1, ch_b = 1'b1;
  logic       en = 1'b1, load = 1'b0, err_clr = 1'b0;
  logic [7:0] init = 8'h00;
  logic [7:0] count;
  logic       dir, step, err;

  int ncmp = 0;
  int nfail = 0;

  logic [7:0] count_m = 8'h00;
  logic       dir_m = 1'b0;
  logic       err_m = 1'b0;
  logic [1:0] cur_ab = 2'b11;

  quad_decoder #(.WIDTH(8), .FILT(2)) dut (
    .clk(clk), .rst(rst), .ch_a(ch_a), .ch_b(ch_b), .en(en), .load(load),
    .init(init), .err_clr(err_clr), .count(count), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  // Position of a phase pair along the up sequence 00 -> 10 -> 11 -> 01.
  function automatic int pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(count_m));
    chk({tag, "_dir"}, 32'(dir), 32'(dir_m));
    chk({tag, "_err"}, 32'(err), 32'(err_m));
  endtask

  // Drive a new phase pair and hold it; load/err_clr may be pulsed on a given edge.
  // load_at is 0 (none) or 5 (the edge a decoded step would land on).
  task automatic apply(input logic [1:0] ab, input int hold, input int load_at,
                       input logic [7:0] ld_val, input int clr_at, input string tag);
    int d;
    logic [31:0] seen, exp_seen;
    d = (pos(ab) - pos(cur_ab) + 4) % 4;
    exp_seen = 32'h0;
    if (clr_at > 0 && clr_at < 5) err_m = 1'b0;
    if (d == 2) err_m = 1'b1;
    else if (clr_at == 5) err_m = 1'b0;
    if (clr_at > 5) err_m = 1'b0;
    if (load_at == 5) begin
      count_m = ld_val;
    end else if (en && (d == 1 || d == 3)) begin
      count_m     = (d == 1) ? count_m + 8'd1 : count_m - 8'd1;
      dir_m       = (d == 1);
      exp_seen[4] = 1'b1;
    end
    cur_ab = ab;

    @(negedge clk);
    ch_a = ab[1];
    ch_b = ab[0];
    seen = 32'h0;
    for (int i = 1; i <= hold; i++) begin
      load    = (i == load_at);
      err_clr = (i == clr_at);
      init    = ld_val;
      @(posedge clk);
      #1;
      seen[i-1] = step;
    end
    load    = 1'b0;
    err_clr = 1'b0;
    chk({tag, "_steps"}, seen, exp_seen);
    check_state(tag);
  endtask

  task automatic step_to(input logic [1:0] ab, input string tag);
    apply(ab, 10, 0, 8'h00, 0, tag);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    load = 1'b1;
    init = v;
    @(posedge clk);
    #1;
    load    = 1'b0;
    count_m = v;
    chk("load_count", 32'(count), 32'(count_m));
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    err_m   = 1'b0;
    chk("err_clr", 32'(err), 32'(err_m));
  endtask

  task automatic glitch_a();
    logic [31:0] seen;
    @(negedge clk);
    ch_a = ~ch_a;
    @(negedge clk);
    ch_a = ~ch_a;
    seen = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      seen[i] = step;
    end
    chk("glitch_steps", seen, 32'h0);
    check_state("glitch");
  endtask

  // Asynchronous reset mid-cycle, then release with phases held at ab.
  task automatic reset_dut(input logic [1:0] ab, input string tag);
    logic [31:0] seen;
    @(posedge clk);
    #3;
    rst  = 1'b0;
    ch_a = ab[1];
    ch_b = ab[0];
    #1;
    chk({tag, "_rst_count"}, 32'(count), 32'h0);
    chk({tag, "_rst_dir"}, 32'(dir), 32'h0);
    chk({tag, "_rst_step"}, 32'(step), 32'h0);
    chk({tag, "_rst_err"}, 32'(err), 32'h0);
    repeat (3) @(negedge clk);
    rst     = 1'b1;
    count_m = 8'h00;
    dir_m   = 1'b0;
    err_m   = 1'b0;
    cur_ab  = ab;
    seen    = 32'h0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      seen[i] = step;
    end
    chk({tag, "_prime_steps"}, seen, 32'h0);
    check_state({tag, "_prime"});
  endtask

  initial begin
    logic [1:0] ab;
    int         load_at, clr_at, hold;
    logic [7:0] ld;

    reset_dut(2'b11, "init");

    step_to(2'b01, "pre_up0");
    step_to(2'b00, "pre_up1");
    do_load(8'h00);
    step_to(2'b10, "up1");
    step_to(2'b11, "up2");
    step_to(2'b01, "up3");
    step_to(2'b00, "up4");

    do_load(8'hFF);
    step_to(2'b10, "wrap_up");
    step_to(2'b00, "wrap_dn1");
    step_to(2'b01, "wrap_dn2");

    glitch_a();

    step_to(2'b00, "to00");
    step_to(2'b11, "jump11");
    pulse_clr();
    apply(2'b00, 10, 0, 8'h00, 5, "jump00_clr");

    en = 1'b0;
    step_to(2'b10, "frz1");
    step_to(2'b11, "frz2");
    step_to(2'b01, "frz3");
    en = 1'b1;
    step_to(2'b00, "thaw");
    apply(2'b10, 10, 5, 8'h55, 0, "load_vs_step");

    for (int n = 0; n < 60; n++) begin
      ab      = 2'($urandom_range(0, 3));
      en      = ($urandom_range(0, 3) != 0);
      load_at = ($urandom_range(0, 7) == 0) ? 5 : 0;
      ld      = 8'($urandom);
      hold    = $urandom_range(7, 12);
      clr_at  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
      apply(ab, hold, load_at, ld, clr_at, "rand");
    end
    en = 1'b1;

    do_load(8'h3C);
    reset_dut(cur_ab, "midrst");
    for (int n = 0; n < 10; n++) begin
      apply(2'($urandom_range(0, 3)), 8, 0, 8'h00, 0, "post_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
